// File: rtl/status_view_if.sv
// Bundle of status inputs from the appliance controller and the
// registered indicator/glyph outputs going to the front panel.
interface status_view_if #(
  parameter int NSTAGE = 8,
  parameter int SW     = $clog2(NSTAGE)
);
  logic              tick;
  logic [2:0]        state;
  logic [NSTAGE-1:0] stage_en;
  logic [SW-1:0]     active_stage;
  logic              click;
  logic              power;
  logic              set_flag;
  logic [5:0]        in_left;
  logic [5:0]        in_middle;
  logic [5:0]        in_right;
  logic [NSTAGE-1:0] stage_led;
  logic              bee_led;
  logic              set_led;
  logic              power_led;
  logic [2:0]        color_led;
  logic [5:0]        out_left;
  logic [5:0]        out_middle;
  logic [5:0]        out_right;

  modport master (
    output tick, state, stage_en, active_stage, click, power, set_flag,
           in_left, in_middle, in_right,
    input  stage_led, bee_led, set_led, power_led, color_led,
           out_left, out_middle, out_right
  );

  modport slave (
    input  tick, state, stage_en, active_stage, click, power, set_flag,
           in_left, in_middle, in_right,
    output stage_led, bee_led, set_led, power_led, color_led,
           out_left, out_middle, out_right
  );
endinterface

// File: rtl/status_view.sv
// Front-panel status view: maps the controller state onto stage LEDs,
// status LEDs, colour LED, digit glyphs and a small beeper sequencer.
// Every output is a register fed from the inputs sampled on the same edge.
module status_view #(
  parameter int NSTAGE    = 8,
  parameter int SW        = $clog2(NSTAGE),
  parameter int CLICK_CYC = 4,
  parameter int FIN_BEEPS = 6
) (
  input logic          cp,
  input logic          rst_n,
  status_view_if.slave bus
);
  localparam logic [2:0] ST_SHUT  = 3'd0;
  localparam logic [2:0] ST_BEGIN = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;
  localparam logic [2:0] ST_PAUSE = 3'd5;
  localparam logic [2:0] ST_FIN   = 3'd6;

  localparam logic [5:0] G_BLANK = 6'd55;
  localparam logic [5:0] G_FIN   = 6'd56;
  localparam logic [5:0] G_PAUSE = 6'd57;
  localparam logic [5:0] G_ERR   = 6'd58;
  localparam logic [5:0] G_BEG_L = 6'd59;
  localparam logic [5:0] G_BEG_M = 6'd60;
  localparam logic [5:0] G_BEG_R = 6'd61;

  localparam logic [7:0] CLICK_LOAD = 8'(CLICK_CYC - 1);
  localparam logic [7:0] FIN_LOAD   = 8'(FIN_BEEPS);

  typedef enum logic [1:0] {B_IDLE, B_CLICK, B_FIN, B_DONE} bstate_t;

  bstate_t           bstate, bstate_nx;
  logic [7:0]        cnt, cnt_nx;
  logic              bee_nx;
  logic [2:0]        st, prev_st;
  logic              fin_entry;
  logic              blink, blink_nx;
  logic [2:0]        color, color_nx;
  logic [NSTAGE-1:0] stage, stage_nx;
  logic              bee, set_r, set_nx, pwr;
  logic [5:0]        left, middle, right;
  logic [5:0]        left_nx, middle_nx, right_nx;

  assign bus.stage_led  = stage;
  assign bus.bee_led    = bee;
  assign bus.set_led    = set_r;
  assign bus.power_led  = pwr;
  assign bus.color_led  = color;
  assign bus.out_left   = left;
  assign bus.out_middle = middle;
  assign bus.out_right  = right;

  // Normalise the state code (7 aliases shutDown) and detect finish entry.
  always_comb begin
    st        = (bus.state == 3'd7) ? ST_SHUT : bus.state;
    fin_entry = (st == ST_FIN) && (prev_st != ST_FIN);
  end

  // Blink phase and colour LED follow the newly sampled state and tick.
  always_comb begin
    blink_nx = 1'b0;
    if (st == ST_RUN || st == ST_FIN)
      blink_nx = blink ^ bus.tick;
    color_nx = color;
    if (bus.tick && st != ST_PAUSE) begin
      if (st == ST_RUN)
        color_nx = color + 3'd1;
      else if (st == ST_ERR)
        color_nx = 3'b100;
      else
        color_nx = 3'd0;
    end
  end

  // Stage LEDs, set LED and glyph selection per state.
  always_comb begin
    stage_nx  = bus.stage_en;
    set_nx    = bus.set_flag;
    left_nx   = bus.in_left;
    middle_nx = bus.in_middle;
    right_nx  = bus.in_right;
    case (st)
      ST_SHUT: begin
        stage_nx  = '0;
        set_nx    = 1'b0;
        left_nx   = G_BLANK;
        middle_nx = G_BLANK;
        right_nx  = G_BLANK;
      end
      ST_BEGIN: begin
        stage_nx  = '1;
        set_nx    = 1'b1;
        left_nx   = G_BEG_L;
        middle_nx = G_BEG_M;
        right_nx  = G_BEG_R;
      end
      ST_FIN: begin
        stage_nx  = '1;
        set_nx    = 1'b1;
        left_nx   = G_FIN;
        middle_nx = G_FIN;
        right_nx  = G_FIN;
      end
      ST_PAUSE: middle_nx = G_PAUSE;
      ST_ERR:   middle_nx = G_ERR;
      ST_RUN: begin
        // An out-of-range index matches no bit, so nothing blinks.
        for (int i = 0; i < NSTAGE; i++)
          if (bus.active_stage == SW'(i))
            stage_nx[i] = blink_nx;
      end
      default: ;
    endcase
  end

  // Beeper FSM state register.
  always_ff @(posedge cp) begin
    if (!rst_n) begin
      bstate <= B_IDLE;
      cnt    <= 8'd0;
    end else begin
      bstate <= bstate_nx;
      cnt    <= cnt_nx;
    end
  end

  // Beeper FSM next-state: finish entry outranks clicks; leaving finish idles.
  always_comb begin
    bstate_nx = bstate;
    cnt_nx    = cnt;
    case (bstate)
      B_IDLE: begin
        if (fin_entry) begin
          bstate_nx = B_FIN;
          cnt_nx    = FIN_LOAD;
        end else if (bus.click) begin
          bstate_nx = B_CLICK;
          cnt_nx    = CLICK_LOAD;
        end
      end
      B_CLICK: begin
        if (fin_entry) begin
          bstate_nx = B_FIN;
          cnt_nx    = FIN_LOAD;
        end else if (bus.click) begin
          cnt_nx = CLICK_LOAD;
        end else if (cnt == 8'd0) begin
          bstate_nx = B_IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      B_FIN: begin
        if (st != ST_FIN) begin
          bstate_nx = B_IDLE;
          cnt_nx    = 8'd0;
        end else if (bus.tick) begin
          if (cnt <= 8'd1) begin
            bstate_nx = B_DONE;
            cnt_nx    = 8'd0;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
      end
      B_DONE: begin
        if (st != ST_FIN)
          bstate_nx = B_IDLE;
      end
      default: bstate_nx = B_IDLE;
    endcase
  end

  // Beeper FSM output: steady during a click, follows blink during finish.
  always_comb begin
    bee_nx = (bstate_nx == B_CLICK) || ((bstate_nx == B_FIN) && blink_nx);
  end

  // Output and bookkeeping registers.
  always_ff @(posedge cp) begin
    if (!rst_n) begin
      prev_st <= ST_SHUT;
      blink   <= 1'b0;
      color   <= 3'd0;
      stage   <= '0;
      bee     <= 1'b0;
      set_r   <= 1'b0;
      pwr     <= 1'b0;
      left    <= G_BLANK;
      middle  <= G_BLANK;
      right   <= G_BLANK;
    end else begin
      prev_st <= st;
      blink   <= blink_nx;
      color   <= color_nx;
      stage   <= stage_nx;
      bee     <= bee_nx;
      set_r   <= set_nx;
      pwr     <= bus.power;
      left    <= left_nx;
      middle  <= middle_nx;
      right   <= right_nx;
    end
  end
endmodule

// File: tb/tb_status_view.sv
// Bench for status_view: a behavioural model predicts every registered
// output; predictions are queued at drive time and compared after the edge.
module tb_status_view;
  localparam int NS        = 6;
  localparam int CLICK_CYC = 4;
  localparam int FIN_BEEPS = 6;

  typedef struct {
    logic [NS-1:0] stage;
    logic          bee;
    logic          set;
    logic          pwr;
    logic [2:0]    color;
    logic [5:0]    l;
    logic [5:0]    m;
    logic [5:0]    r;
  } exp_t;

  logic cp = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic       m_blink;
  logic [2:0] m_color;
  int         m_bst;
  int         m_cnt;
  int         m_prev;

  status_view_if #(.NSTAGE(NS)) bus();

  status_view #(
    .NSTAGE(NS), .CLICK_CYC(CLICK_CYC), .FIN_BEEPS(FIN_BEEPS)
  ) dut (
    .cp(cp), .rst_n(rst_n), .bus(bus)
  );

  always #5 cp = ~cp;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural prediction of the outputs after the coming edge.
  task automatic model(output exp_t e);
    int   s;
    int   a;
    logic fe;
    s = (bus.state == 3'd7) ? 0 : int'(bus.state);
    if (!rst_n) begin
      m_blink = 1'b0; m_color = 3'd0; m_bst = 0; m_cnt = 0; m_prev = 0;
      e.stage = '0; e.bee = 1'b0; e.set = 1'b0; e.pwr = 1'b0; e.color = 3'd0;
      e.l = 6'd55; e.m = 6'd55; e.r = 6'd55;
      return;
    end
    fe = (s == 6) && (m_prev != 6);
    m_prev = s;
    if (s == 3 || s == 6) m_blink = m_blink ^ bus.tick;
    else m_blink = 1'b0;
    if (bus.tick) begin
      if (s == 3) m_color = m_color + 3'd1;
      else if (s == 4) m_color = 3'b100;
      else if (s != 5) m_color = 3'd0;
    end
    case (m_bst)
      0: if (fe) begin m_bst = 2; m_cnt = FIN_BEEPS; end
         else if (bus.click) begin m_bst = 1; m_cnt = CLICK_CYC - 1; end
      1: if (fe) begin m_bst = 2; m_cnt = FIN_BEEPS; end
         else if (bus.click) m_cnt = CLICK_CYC - 1;
         else if (m_cnt == 0) m_bst = 0;
         else m_cnt--;
      2: if (s != 6) m_bst = 0;
         else if (bus.tick) begin
           m_cnt--;
           if (m_cnt == 0) m_bst = 3;
         end
      default: if (s != 6) m_bst = 0;
    endcase
    e.bee   = (m_bst == 1) || (m_bst == 2 && m_blink);
    e.pwr   = bus.power;
    e.color = m_color;
    e.stage = bus.stage_en;
    e.set   = bus.set_flag;
    e.l = bus.in_left; e.m = bus.in_middle; e.r = bus.in_right;
    case (s)
      0: begin e.stage = '0; e.set = 1'b0; e.l = 55; e.m = 55; e.r = 55; end
      1: begin e.stage = '1; e.set = 1'b1; e.l = 59; e.m = 60; e.r = 61; end
      6: begin e.stage = '1; e.set = 1'b1; e.l = 56; e.m = 56; e.r = 56; end
      5: e.m = 57;
      4: e.m = 58;
      3: begin
        a = int'(bus.active_stage);
        if (a < NS) e.stage[a] = m_blink;
      end
      default: ;
    endcase
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected one entry");
      return;
    end
    e = sb.pop_front();
    check_val("stage_led",  bus.stage_led,  e.stage);
    check_val("bee_led",    bus.bee_led,    e.bee);
    check_val("set_led",    bus.set_led,    e.set);
    check_val("power_led",  bus.power_led,  e.pwr);
    check_val("color_led",  bus.color_led,  e.color);
    check_val("out_left",   bus.out_left,   e.l);
    check_val("out_middle", bus.out_middle, e.m);
    check_val("out_right",  bus.out_right,  e.r);
  endtask

  // Drive one cycle of tick/click, predict, clock, compare.
  task automatic step(input logic t, input logic c);
    exp_t e;
    bus.tick  = t;
    bus.click = c;
    model(e);
    sb.push_back(e);
    @(posedge cp);
    #1;
    check_out();
    bus.tick  = 1'b0;
    bus.click = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.tick = 0; bus.click = 0; bus.state = 3'd3; bus.stage_en = 6'h0F;
    bus.active_stage = 3'd2; bus.power = 1'b1; bus.set_flag = 1'b1;
    bus.in_left = 6'd1; bus.in_middle = 6'd2; bus.in_right = 6'd3;
    #1;

    // Reset with state=run, then release.
    step(1, 1);
    step(1, 0);
    check_val("rst_stage", bus.stage_led, 6'h00);
    check_val("rst_glyph", bus.out_left, 6'd55);
    check_val("rst_power", bus.power_led, 1'b0);
    rst_n = 1'b1;
    step(1, 0);
    check_val("post_rst_color", bus.color_led, 3'd1);
    step(0, 0);
    step(1, 0);

    // Run blink on stage 2.
    bus.state = 3'd0;
    step(1, 0);
    bus.state = 3'd3;
    step(0, 0);
    check_val("run_idle_stage", bus.stage_led, 6'h0B);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0);
      check_val("run_stage", bus.stage_led, (k % 2 == 1) ? 6'h0F : 6'h0B);
      check_val("run_color", bus.color_led, k[2:0]);
      step(0, 0);
    end

    // Click, second click two cycles later.
    bus.state = 3'd1;
    for (int i = 0; i < 9; i++) begin
      step(0, (i == 0 || i == 2));
      check_val("click_bee", bus.bee_led, (i <= 5));
    end

    // Finish sequence, then a click that must stay silent.
    bus.state = 3'd3;
    step(1, 0);
    bus.state = 3'd6;
    for (int i = 0; i < 20; i++) step((i % 2 == 1), 0);
    check_val("fin_bee_done", bus.bee_led, 1'b0);
    step(0, 1);
    check_val("fin_click", bus.bee_led, 1'b0);
    check_val("fin_stage", bus.stage_led, 6'h3F);
    step(0, 0);

    // Pause holds colour, error forces 4.
    bus.state = 3'd0;
    step(1, 0);
    bus.state = 3'd3;
    for (int i = 0; i < 5; i++) step(1, 0);
    bus.state = 3'd5;
    step(1, 0);
    step(1, 0);
    check_val("pause_color", bus.color_led, 3'd5);
    check_val("pause_mid", bus.out_middle, 6'd57);
    bus.state = 3'd4;
    step(1, 0);
    check_val("err_color", bus.color_led, 3'b100);
    check_val("err_mid", bus.out_middle, 6'd58);

    // Out-of-range active stage and state code 7.
    bus.state = 3'd3;
    bus.active_stage = 3'd6;
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      check_val("oor_stage", bus.stage_led, 6'h0F);
    end
    bus.state = 3'd7;
    step(1, 0);
    check_val("st7_stage", bus.stage_led, 6'h00);
    check_val("st7_glyph", bus.out_right, 6'd55);
    check_val("st7_color", bus.color_led, 3'd0);

    // Reset mid-beep aborts the beep.
    bus.state = 3'd1;
    step(0, 1);
    rst_n = 1'b0;
    step(0, 0);
    rst_n = 1'b1;
    step(0, 0);
    check_val("rst_abort_bee", bus.bee_led, 1'b0);

    // Random traffic with sticky states.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 5) == 0) bus.state = 3'($urandom_range(0, 7));
      bus.stage_en     = NS'($urandom);
      bus.active_stage = 3'($urandom_range(0, 7));
      bus.power        = 1'($urandom);
      bus.set_flag     = 1'($urandom);
      bus.in_left      = 6'($urandom);
      bus.in_middle    = 6'($urandom);
      bus.in_right     = 6'($urandom);
      rst_n            = ($urandom_range(0, 39) != 0);
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/status_view.md
STATUS_VIEW -- requirements
Module: status_view

Interface
REQ-001 Parameter NSTAGE, default 8: number of program-stage indicator LEDs, 2..16.
REQ-002 Parameter SW, default $clog2(NSTAGE): width of active_stage.
REQ-003 Parameter CLICK_CYC, default 4: cp cycles the beeper stays on after a click, 1..255.
REQ-004 Parameter FIN_BEEPS, default 6: blink half-periods the beeper toggles in finish state, 1..255.
REQ-005 Port cp, input, 1: sole clock, rising-edge.
REQ-006 Port rst_n, input, 1: synchronous, active-low reset.
REQ-007 Port tick, input, 1: one-cp-cycle strobe, nominally once per second.
REQ-008 Port state, input, 3: 0 shutDown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish; 7 treated as shutDown.
REQ-009 Port stage_en, input, NSTAGE: selected program stages.
REQ-010 Port active_stage, input, SW: index of the running stage.
REQ-011 Port click, input, 1: one-cycle key-press pulse.
REQ-012 Port power, input, 1; set_flag, input, 1: power and set status bits.
REQ-013 Port in_left, in_middle, in_right, input, 6 each: digit glyph codes.
REQ-014 Port stage_led, output, NSTAGE; bee_led, set_led, power_led, output, 1 each.
REQ-015 Port color_led, output, 3; out_left, out_middle, out_right, output, 6 each: glyph codes to the digit driver.

Function
REQ-016 All outputs are registered: each reflects the inputs sampled on the previous rising cp edge.
REQ-017 Register blink toggles on every tick in run or finish; it clears to 0 in every other state.
REQ-018 Glyph codes: shutDown all 55; begin 59/60/61; finish all 56; pause middle 57; error middle 58; otherwise pass in_*; left and right pass in_* in pause and error.
REQ-019 stage_led: all 0 in shutDown; all 1 in begin and finish; otherwise equal to stage_en.
REQ-020 In run, stage_led[active_stage] equals blink; an active_stage >= NSTAGE causes no bit to blink.
REQ-021 power_led equals power in every state.
REQ-022 set_led is 1 in begin and finish, 0 in shutDown, and set_flag otherwise.
REQ-023 color_led increments mod 8 on tick in run and is 3'b100 on tick in error.
REQ-024 color_led holds its value in pause and clears to 0 on tick in any other state.
REQ-025 The beeper FSM has states B_IDLE, B_CLICK, B_FIN and B_DONE.
REQ-026 B_IDLE: a click loads a cnt with CLICK_CYC-1 and goes to B_CLICK; entering finish loads FIN_BEEPS and goes to B_FIN.
REQ-027 B_CLICK: bee_led is 1 and cnt decrements each cp cycle; at cnt 0 the FSM returns to B_IDLE.
REQ-028 A click in B_CLICK reloads cnt with CLICK_CYC-1.
REQ-029 B_FIN: bee_led equals blink and cnt decrements on each tick; when cnt reaches 0 on a tick, the FSM goes to B_DONE.
REQ-030 B_DONE: bee_led is 0 and clicks are ignored; leaving finish goes to B_IDLE.
REQ-031 Entering finish while in B_CLICK goes to B_FIN; finish entry has priority over a simultaneous click.
REQ-032 Leaving finish from B_FIN goes to B_IDLE with bee_led 0 on the next cycle.
REQ-033 A simultaneous tick and state change is evaluated against the newly sampled state.
REQ-034 Finish entry is the cycle on which state is 6 after a non-6 value was sampled on the previous cycle.

Reset
REQ-035 While rst_n is 0 at a cp edge, the following clear to 0: blink, color_led, cnt, stage_led, bee_led, set_led, power_led.
REQ-036 While rst_n is 0 at a cp edge, the beeper FSM returns to B_IDLE and out_* take 55.
REQ-037 Reset mid-operation aborts any beep in progress and any count in progress; the previous state register is reset to shutDown.

Verification
REQ-038 Run the reset scenario: state=3, rst_n=0 for 2 cycles, then 1 -> all outputs 0 and glyphs 55 during reset, then run behaviour resumes.
REQ-039 Run the run-blink scenario: state=3, stage_en=8'h0F, active_stage=2, 4 ticks -> stage_led alternates 8'h0B/8'h0F and color_led counts 1,2,3,4.
REQ-040 Run the click scenario: CLICK_CYC=4, click at cycle 0 and again at cycle 2 -> bee_led is 1 for cycles 1..6, then 0.
REQ-041 Run the finish scenario: state 3->6 with FIN_BEEPS=6 -> bee_led follows blink for 6 ticks, then stays 0; a later click gives no beep; stage_led all 1.
REQ-042 Run the pause/error scenario: color_led=5, state=5, ticks -> holds 5 and middle=57; then state=4, tick -> color_led=3'b100 and middle=58.
REQ-043 Run the boundary scenario: active_stage=NSTAGE in run -> no stage blinks; state=7 -> identical to shutDown.
